// File: rtl/cpu_defs.sv
// ----------------------------------------------------------------------------
// cpu_defs: types shared between fetch, execute and the branch target buffer.
//
// Contents
//   BTB_ENTRY_NUM / BTB_TAG_W : default BTB geometry
//   btb_predict_t             : registered BTB prediction seen by fetch
//   btb_update_t              : resolved-branch training record from execute
//   btb_entry_t               : one BTB entry at the default tag width
// ----------------------------------------------------------------------------
package cpu_defs;

  localparam int BTB_ENTRY_NUM = 64;
  localparam int BTB_TAG_W     = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] npc;
  } btb_predict_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        is_branch;
    logic        is_uncond;
  } btb_update_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [29:0]          target;
    logic [1:0]           ctr;
    logic                 uncond;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// ----------------------------------------------------------------------------
// btb_sat_ctr: combinational 2-bit saturating direction counter step.
//
// Ports
//   ctr_i  in   2  current counter value
//   inc_i  in   1  1 = step towards strongly taken, 0 = towards strongly not-taken
//   ctr_o  out  2  next counter value, clamped to [2'b00, 2'b11]
// ----------------------------------------------------------------------------
module btb_sat_ctr (
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && (c != 2'b11)) begin
      r = c + 2'd1;
    end else if (!up && (c != 2'b00)) begin
      r = c - 2'd1;
    end
    return r;
  endfunction

  assign ctr_o = sat_step(ctr_i, inc_i);

endmodule

// File: rtl/btb.sv
// ----------------------------------------------------------------------------
// btb: direct-mapped branch target buffer answering fetch-stage queries.
//
// Fetch presents its next PC every cycle; one cycle later btb_predict holds a
// registered taken/target prediction for it. Execute trains the table with
// resolved branches. Entries carry a partial tag, a word-aligned target, a
// 2-bit saturating direction counter and an unconditional flag.
//
// Ports
//   clk          in   1              clock
//   rst          in   1              asynchronous active-high reset
//   btb_is_stall in   1              fetch stalled: hold btb_predict
//   btb_pc       in   32             lookup PC
//   btb_predict  out  btb_predict_t  prediction for the last non-stalled btb_pc
//   upd          in   btb_update_t   resolved-branch training record
//
// Build option
//   BTB_FWD_EN : when defined, a lookup that hits the index being written in
//                the same cycle sees the post-update entry; otherwise the
//                lookup reads the pre-update contents.
// ----------------------------------------------------------------------------
module btb
  import cpu_defs::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM,
  parameter int TAG_W     = BTB_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btb_is_stall,
  input  logic [31:0]  btb_pc,
  output btb_predict_t btb_predict,
  input  btb_update_t  upd
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  // Entry storage, one array per field.
  logic             valid_q [ENTRY_NUM];
  logic [TAG_W-1:0] tag_q   [ENTRY_NUM];
  logic [29:0]      tgt_q   [ENTRY_NUM];
  logic [1:0]       ctr_q   [ENTRY_NUM];
  logic             unc_q   [ENTRY_NUM];

  logic             pred_valid_q;
  logic [31:0]      pred_npc_q;

  // ---------------- training path: next value of the addressed entry -------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr_step;

  logic             wr_en;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [29:0]      ent_tgt_d;
  logic [1:0]       ent_ctr_d;
  logic             ent_unc_d;

  assign u_idx = upd.pc[IDX_W+1:2];
  assign u_tag = upd.pc[IDX_W+2 +: TAG_W];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  btb_sat_ctr u_sat_ctr (
    .ctr_i (ctr_q[u_idx]),
    .inc_i (upd.taken),
    .ctr_o (u_ctr_step)
  );

  always_comb begin
    wr_en       = 1'b0;
    ent_valid_d = valid_q[u_idx];
    ent_tag_d   = tag_q[u_idx];
    ent_tgt_d   = tgt_q[u_idx];
    ent_ctr_d   = ctr_q[u_idx];
    ent_unc_d   = unc_q[u_idx];
    if (upd.valid) begin
      if (upd.is_branch) begin
        if (u_hit) begin
          wr_en     = 1'b1;
          ent_ctr_d = u_ctr_step;
          ent_unc_d = upd.is_uncond;
          if (upd.taken) begin
            ent_tgt_d = upd.target[31:2];
          end
        end else if (upd.taken) begin
          // Miss on a taken branch: claim the slot, starting weakly taken.
          wr_en       = 1'b1;
          ent_valid_d = 1'b1;
          ent_tag_d   = u_tag;
          ent_tgt_d   = upd.target[31:2];
          ent_ctr_d   = 2'b10;
          ent_unc_d   = upd.is_uncond;
        end
      end else if (u_hit) begin
        // A non-branch matched the tag: the entry is an alias, drop it.
        wr_en       = 1'b1;
        ent_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[u_idx] <= ent_valid_d;
      ctr_q[u_idx]   <= ent_ctr_d;
    end
  end

  // Tag, target and uncond are only meaningful while valid is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[u_idx] <= ent_tag_d;
      tgt_q[u_idx] <= ent_tgt_d;
      unc_q[u_idx] <= ent_unc_d;
    end
  end

  // ---------------- lookup path: read entry, form prediction ---------------
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [29:0]      rd_tgt;
  logic [1:0]       rd_ctr;
  logic             rd_unc;
  logic             pred_valid_d;
  logic [31:0]      pred_npc_d;

  assign l_idx = btb_pc[IDX_W+1:2];
  assign l_tag = btb_pc[IDX_W+2 +: TAG_W];

`ifdef BTB_FWD_EN
  logic fwd;
  assign fwd      = wr_en && (u_idx == l_idx);
  assign rd_valid = fwd ? ent_valid_d : valid_q[l_idx];
  assign rd_tag   = fwd ? ent_tag_d   : tag_q[l_idx];
  assign rd_tgt   = fwd ? ent_tgt_d   : tgt_q[l_idx];
  assign rd_ctr   = fwd ? ent_ctr_d   : ctr_q[l_idx];
  assign rd_unc   = fwd ? ent_unc_d   : unc_q[l_idx];
`else
  assign rd_valid = valid_q[l_idx];
  assign rd_tag   = tag_q[l_idx];
  assign rd_tgt   = tgt_q[l_idx];
  assign rd_ctr   = ctr_q[l_idx];
  assign rd_unc   = unc_q[l_idx];
`endif

  assign pred_valid_d = rd_valid && (rd_tag == l_tag) && (rd_unc || rd_ctr[1]);
  assign pred_npc_d   = pred_valid_d ? {rd_tgt, 2'b00} : 32'h0;

  // ---------------- prediction register (held while fetch stalls) ----------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_npc_q   <= 32'h0;
    end else if (!btb_is_stall) begin
      pred_valid_q <= pred_valid_d;
      pred_npc_q   <= pred_npc_d;
    end
  end

  assign btb_predict = {pred_valid_q, pred_npc_q};

  // PC bits outside index/tag, target byte offset and the weak counter bit
  // play no part in the prediction.
  logic unused_bits;
  assign unused_bits = ^{btb_pc, upd.pc, upd.target, rd_ctr[0]};

endmodule

// File: tb/tb_btb.sv
module tb_btb;
  import cpu_defs::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         btb_is_stall;
  logic [31:0]  btb_pc;
  btb_predict_t btb_predict;
  btb_update_t  upd;

  btb dut (
    .clk          (clk),
    .rst          (rst),
    .btb_is_stall (btb_is_stall),
    .btb_pc       (btb_pc),
    .btb_predict  (btb_predict),
    .upd          (upd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic ev, input logic [31:0] en);
    n_checks++;
    if (btb_predict.valid !== ev || btb_predict.npc !== en) begin
      n_fail++;
      $display("FAIL %s @%0t: got valid=%0b npc=%08h, expected valid=%0b npc=%08h",
               name, $time, btb_predict.valid, btb_predict.npc, ev, en);
    end
  endtask

  // ---------------- reference model: table of entries by index ------------
  bit          m_v   [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  bit          m_unc [64];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int m_tg(input logic [31:0] pc);
    return int'((pc >> 8) & 32'hffff);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0;
      m_ctr[i] = 1;
    end
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output logic v, output logic [31:0] n);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_v[i] && (m_tag[i] == m_tg(pc));
    v   = hit && (m_unc[i] || m_ctr[i] >= 2);
    n   = v ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void m_update(input btb_update_t u);
    int i;
    bit hit;
    if (!u.valid) return;
    i   = m_idx(u.pc);
    hit = m_v[i] && (m_tag[i] == m_tg(u.pc));
    if (u.is_branch) begin
      if (hit) begin
        if (u.taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = u.target & ~32'h3;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
        m_unc[i] = u.is_uncond;
      end else if (u.taken) begin
        m_v[i]   = 1;
        m_tag[i] = m_tg(u.pc);
        m_tgt[i] = u.target & ~32'h3;
        m_ctr[i] = 2;
        m_unc[i] = u.is_uncond;
      end
    end else if (hit) begin
      m_v[i] = 0;
    end
  endfunction

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] pc;
    btb_update_t u;
    logic        ev;
    logic [31:0] enpc;
  } vec_t;

  vec_t vecs[$];

  function automatic btb_update_t mku(input logic [31:0] pc, input logic [31:0] tgt,
                                      input logic tk, input logic br, input logic unc);
    btb_update_t u;
    u.valid = 1'b1; u.pc = pc; u.target = tgt;
    u.taken = tk; u.is_branch = br; u.is_uncond = unc;
    return u;
  endfunction

  function automatic void add(input string name, input logic st, input logic [31:0] pc,
                              input btb_update_t u, input logic ev, input logic [31:0] en);
    vec_t v;
    v.name = name; v.stall = st; v.pc = pc; v.u = u; v.ev = ev; v.enpc = en;
    vecs.push_back(v);
  endfunction

  localparam logic [31:0] PA = 32'h1c000010;
  localparam logic [31:0] TA = 32'h1c000100;
  localparam logic [31:0] PL = 32'h1c000110;
  localparam logic [31:0] TL = 32'h1c000200;
  localparam logic [31:0] PC = 32'h1c000020;
  localparam logic [31:0] TC = 32'h1c000300;
  localparam logic [31:0] PU = 32'h1c000030;
  localparam logic [31:0] TU = 32'h1c000400;
  localparam logic [31:0] P0 = 32'h1c000000;

  btb_update_t NOU;
  logic        coll_v;
  logic [31:0] coll_n;

  // random-phase state
  logic [31:0] r_pc;
  btb_update_t r_u;
  logic        r_st, p_v, exp_v;
  logic [31:0] p_n, exp_n;

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = 32'h1c000000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    NOU = '0;
`ifdef BTB_FWD_EN
    coll_v = 1'b1; coll_n = TC;
`else
    coll_v = 1'b0; coll_n = 32'h0;
`endif
    add("reset_lookup",       0, P0, NOU,                      0, 0);
    add("alloc_no_lookup",    0, P0, mku(PA, TA, 1, 1, 0),     0, 0);
    add("first_hit",          0, PA, NOU,                      1, TA);
    add("nt_train_1",         0, P0, mku(PA, TA, 0, 1, 0),     0, 0);
    add("nt_train_2",         0, P0, mku(PA, TA, 0, 1, 0),     0, 0);
    add("ctr00_predict",      0, PA, NOU,                      0, 0);
    add("t_train_1",          0, P0, mku(PA, TA, 1, 1, 0),     0, 0);
    add("ctr01_predict",      0, PA, NOU,                      0, 0);
    add("t_train_2",          0, P0, mku(PA, TA, 1, 1, 0),     0, 0);
    add("ctr10_predict",      0, PA, NOU,                      1, TA);
    add("stall_invalidate",   1, PA, mku(PA, 32'h0, 0, 0, 0),  1, TA);
    add("stall_hold_2",       1, PA, NOU,                      1, TA);
    add("stall_hold_3",       1, PA, NOU,                      1, TA);
    add("unstall_invalid",    0, PA, NOU,                      0, 0);
    add("realloc_a",          0, P0, mku(PA, TA, 1, 1, 0),     0, 0);
    add("realloc_a_hit",      0, PA, NOU,                      1, TA);
    add("alias_miss",         0, PL, NOU,                      0, 0);
    add("alias_alloc",        0, P0, mku(PL, TL, 1, 1, 0),     0, 0);
    add("alias_hit",          0, PL, NOU,                      1, TL);
    add("orig_evicted",       0, PA, NOU,                      0, 0);
    add("collision",          0, PC, mku(PC, TC, 1, 1, 0),     coll_v, coll_n);
    add("after_collision",    0, PC, NOU,                      1, TC);
    add("uncond_alloc",       0, P0, mku(PU, TU, 1, 1, 1),     0, 0);
    add("uncond_nt",          0, P0, mku(PU, TU, 0, 1, 1),     0, 0);
    add("uncond_predict",     0, PU, NOU,                      1, TU);
    add("sat_up_1",           0, P0, mku(PC, TC, 1, 1, 0),     0, 0);
    add("sat_up_2",           0, P0, mku(PC, TC, 1, 1, 0),     0, 0);
    add("sat_down",           0, P0, mku(PC, TC, 0, 1, 0),     0, 0);
    add("sat_predict",        0, PC, NOU,                      1, TC);

    rst = 1'b1; btb_is_stall = 1'b0; btb_pc = 32'h0; upd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 32'h0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      btb_is_stall = vecs[k].stall;
      btb_pc       = vecs[k].pc;
      upd          = vecs[k].u;
      step();
      check(vecs[k].name, vecs[k].ev, vecs[k].enpc);
    end
    btb_is_stall = 1'b0; upd = '0; btb_pc = P0;

    // ---------------- randomized phase against the model -----------------
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
    exp_v = 1'b0; exp_n = 32'h0;
    check("reset_before_random", 1'b0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      r_pc = rnd_pc();
      r_st = ($urandom_range(0, 4) == 0);
      r_u.valid     = $urandom_range(0, 1);
      r_u.pc        = rnd_pc();
      r_u.target    = $urandom;
      r_u.taken     = $urandom_range(0, 1);
      r_u.is_branch = ($urandom_range(0, 7) != 0);
      r_u.is_uncond = ($urandom_range(0, 3) == 0);
`ifdef BTB_FWD_EN
      m_update(r_u);
      m_predict(r_pc, p_v, p_n);
`else
      m_predict(r_pc, p_v, p_n);
      m_update(r_u);
`endif
      if (!r_st) begin
        exp_v = p_v; exp_n = p_n;
      end
      btb_pc = r_pc; btb_is_stall = r_st; upd = r_u;
      step();
      check("random", exp_v, exp_n);
    end
    btb_is_stall = 1'b0; upd = '0;

    // ---------------- asynchronous reset mid-operation -------------------
    btb_pc = P0; upd = mku(32'h1c000040, 32'h1c000500, 1, 1, 0);
    step();
    upd = '0; btb_pc = 32'h1c000040;
    step();
    check("pre_reset_hit", 1'b1, 32'h1c000500);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_clear", 1'b0, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("reset_cleared_entry", 1'b0, 32'h0);
    btb_pc = P0; upd = mku(32'h1c000040, 32'h1c000500, 1, 1, 0);
    step();
    check("post_reset_alloc", 1'b0, 32'h0);
    upd = '0; btb_pc = 32'h1c000040;
    step();
    check("post_reset_first_hit", 1'b1, 32'h1c000500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb.md
Name: btb

Overview:
- Branch target buffer. Responder side of the fetch-stage BTB query interface.
- Fetch drives a PC (its npc) each cycle. The btb returns a registered prediction one cycle later; fetch uses it to choose the next PC.
- Trained by the execute stage through a resolved-branch update port.
- Direct-mapped, register-array storage, 2-bit saturating direction counters.

Parameters:
- ENTRY_NUM, 64: entry count, power of two; IDX_W = log2(ENTRY_NUM).
- TAG_W, 16: partial tag width, taken from pc[IDX_W+2 +: TAG_W]. Aliasing beyond this is tolerated.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- btb_is_stall  in  1  fetch stalled; hold the prediction output.
- btb_pc  in  32  lookup PC (fetch npc).
- btb_predict  out  btb_predict_t{valid, npc[31:0]}  prediction for the btb_pc of the previous non-stalled cycle.
- upd  in  btb_update_t{valid, pc[31:0], target[31:0], taken, is_branch, is_uncond}  resolved branch from execute.

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_W].
- Entry fields: valid, tag, target[31:2], ctr[1:0], uncond.
- Reset (async, rst=1):
  - all entry valid=0, ctr=2'b01;
  - btb_predict.valid=0, btb_predict.npc=0.
- Lookup, latency exactly 1 cycle:
  - On posedge with btb_is_stall=0, read entry[idx(btb_pc)] and register the result.
  - hit = valid & tag match.
  - btb_predict.valid = hit & (uncond | ctr[1]).
  - btb_predict.npc = {target, 2'b00} when valid, otherwise 0.
- Stall: btb_is_stall=1 at a posedge leaves the btb_predict registers unchanged. The held value may be stale if an update hits the same entry; this is accepted.
- Update on posedge, when upd.valid=1 (independent of stall):
  - is_branch & hit:
    - taken: ctr saturating increment (max 2'b11) and target <= upd.target[31:2];
    - not taken: ctr saturating decrement (min 2'b00);
    - uncond <= upd.is_uncond.
  - is_branch & miss & taken: allocate/overwrite entry with valid=1, new tag and target, ctr=2'b10, uncond=upd.is_uncond.
  - is_branch & miss & not taken: no change.
  - ~is_branch & hit (aliased false prediction): valid <= 0.
  - ~is_branch & miss: no change.
- Read/write collision, same cycle and same idx: the lookup returns pre-update contents (read-before-write), unless BTB_FWD_EN is defined.
- Update and lookup to different indices in the same cycle are fully independent.
- No flush input. Fetch discards predictions itself on redirect.
- Reset asserted mid-operation clears everything asynchronously. First valid prediction is no earlier than the 2nd posedge after deassertion, given an intervening update.

Optional Feature:
- Macro: BTB_FWD_EN.
- Defined: on a same-cycle, same-idx collision, the lookup sees the post-update entry value. Uses the same combinational next-entry logic as the write path, so a just-allocated taken branch is predicted at once.
- Undefined: read-before-write as above. Lower area and shorter path.

Decomposition:
- cpu_defs package: btb_predict_t (already shared with fetch), btb_update_t, btb_entry_t, and BTB_ENTRY_NUM/BTB_TAG_W defaults.
- Sub-module btb_sat_ctr: pure combinational 2-bit saturating inc/dec. Used for the update path and, under BTB_FWD_EN, the forward path.

Test Plan:
- Reset then lookup 0x1c000000 -> next cycle btb_predict.valid=0, npc=0.
- Update {pc=0x1c000010, target=0x1c000100, taken=1, is_branch=1, is_uncond=0}; next cycle lookup 0x1c000010 -> following cycle valid=1, npc=0x1c000100.
- Train the same branch not-taken twice (ctr 10->01->00) -> valid=0. One taken update (ctr 01) -> still valid=0. Second taken (ctr 10) -> valid=1.
- Lookup 0x1c000010 with btb_is_stall=1 for 3 cycles after the entry is invalidated by a ~is_branch update -> btb_predict holds the prior valid=1/0x1c000100 throughout; deasserting stall gives valid=0.
- Alias 0x1c000010 vs 0x1c000110 (ENTRY_NUM=64, same idx, different tag) -> a lookup of the alias gives valid=0. A taken update of the alias overwrites, and the original then misses.
- Same-cycle taken-allocate and lookup of 0x1c000020 -> valid=0 without BTB_FWD_EN; valid=1, npc=target with BTB_FWD_EN.
